// File: rtl/cwru_tx_pkg.sv
// Shared definitions for the CWRU link: controller state encoding and the key frame codes
// that the RX decoder also matches against.
package cwru_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        GAP
    } tx_state_t;

    localparam int FRAME_BITS = 8;

    // Key k sends (k+1) "10" pairs, MSB first, zero-filled.
    localparam logic [FRAME_BITS-1:0] KEY0_CODE = 8'b1000_0000;
    localparam logic [FRAME_BITS-1:0] KEY1_CODE = 8'b1010_0000;
    localparam logic [FRAME_BITS-1:0] KEY2_CODE = 8'b1010_1000;
    localparam logic [FRAME_BITS-1:0] KEY3_CODE = 8'b1010_1010;

    function automatic logic [FRAME_BITS-1:0] frame_code(input logic [1:0] key);
        case (key)
            2'd0:    return KEY0_CODE;
            2'd1:    return KEY1_CODE;
            2'd2:    return KEY2_CODE;
            default: return KEY3_CODE;
        endcase
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] onehot);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (onehot[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: the first pending key at or after the pointer
// (with wrap-around) wins.
module rr_arbiter4 (
    input  logic [3:0] pending,
    input  logic [1:0] pointer,
    output logic [3:0] grant,
    output logic       valid
);

    logic [1:0] idx;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch can be inferred.
        grant = 4'b0000;
        idx   = 2'd0;
        // Walk from farthest to nearest so the closest pending key is written last and wins.
        for (int i = 3; i >= 0; i--) begin
            idx = pointer + 2'(i);
            if (pending[idx]) grant = 4'b0001 << idx;
        end
        valid = |pending;
    end

endmodule

// File: rtl/key_frame_tx_scheduler.sv
// Queues key presses, picks one round-robin and serializes its 8-bit frame MSB first,
// followed by a low inter-frame gap. Define REQ_SYNC_EN to add a 2-flop REQ synchronizer.
module key_frame_tx_scheduler
    import cwru_tx_pkg::*;
#(
    parameter int BIT_CYCLES = 6250,
    parameter int GAP_BITS   = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    output logic       TX_OUT,
    output logic       BUSY,
    output logic [3:0] GRANT,
    output logic       DONE
);

    localparam int GAP_TOTAL = GAP_BITS * BIT_CYCLES;
    localparam int BIT_CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int GAP_CNT_W = (GAP_TOTAL > 1) ? $clog2(GAP_TOTAL) : 1;
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(BIT_CYCLES - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_TOTAL - 1);

    tx_state_t             state, state_next;
    logic [3:0]            req_s, req_d, rise, pending;
    logic [1:0]            pointer, win_idx;
    logic [3:0]            arb_grant;
    logic                  arb_valid;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [2:0]            bit_idx;
    logic [GAP_CNT_W-1:0]  gap_cnt, gap_cnt_next;
    logic [FRAME_BITS-1:0] shift;
    logic                  bit_term, last_bit, gap_last, load_take;
    logic                  busy_next, done_next;

`ifdef REQ_SYNC_EN
    logic [3:0] sync_q1, sync_q2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q1 <= 4'b1111;
            sync_q2 <= 4'b1111;
        end else begin
            sync_q1 <= REQ;
            sync_q2 <= sync_q1;
        end
    end

    assign req_s = sync_q2;
`else
    assign req_s = REQ;
`endif

    assign rise      = req_s & ~req_d;
    assign win_idx   = onehot_to_idx(arb_grant);
    assign bit_term  = (state == SEND) && (bit_cnt == BIT_LAST);
    assign last_bit  = bit_term && (bit_idx == 3'(FRAME_BITS - 1));
    assign gap_last  = (state == GAP) && (gap_cnt == GAP_LAST);
    assign load_take = (state == LOAD) && arb_valid;
    // The shift register empties to zero after the last bit, so the line idles low.
    assign TX_OUT    = shift[FRAME_BITS-1];

    rr_arbiter4 u_arb (
        .pending (pending),
        .pointer (pointer),
        .grant   (arb_grant),
        .valid   (arb_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|pending) state_next = LOAD;
            LOAD:    state_next = arb_valid ? SEND : IDLE;
            SEND:    if (last_bit) state_next = GAP;
            GAP:     if (gap_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so BUSY and DONE come straight from flops.
    always_comb begin
        gap_cnt_next = (state == GAP) ? gap_cnt + GAP_CNT_W'(1) : '0;
        busy_next    = (state_next != IDLE);
        done_next    = (state_next == GAP) && (gap_cnt_next == GAP_LAST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: a high reset value on req_d means keys held through reset never look like new edges.
            req_d   <= 4'b1111;
            pending <= '0;
            pointer <= '0;
            bit_cnt <= '0;
            bit_idx <= '0;
            gap_cnt <= '0;
            shift   <= '0;
            GRANT   <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            // NOTE: state updates are non-blocking so every flop sees this cycle's values.
            req_d   <= req_s;
            // Set wins: a fresh edge on the key being served survives its own clear.
            pending <= (pending & ~(load_take ? arb_grant : 4'b0000)) | rise;
            gap_cnt <= gap_cnt_next;
            BUSY    <= busy_next;
            DONE    <= done_next;
            case (state)
                LOAD: begin
                    if (arb_valid) begin
                        GRANT   <= arb_grant;
                        shift   <= frame_code(win_idx);
                        pointer <= win_idx + 2'd1;
                    end
                    bit_cnt <= '0;
                    bit_idx <= '0;
                end
                SEND: begin
                    if (bit_term) begin
                        bit_cnt <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        shift   <= shift << 1;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                    end
                end
                GAP: if (gap_last) GRANT <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_frame_tx_scheduler.sv
// Directed bench for key_frame_tx_scheduler: a fast instance (4 cycles/bit) for protocol
// checks and a full-rate instance (6250 cycles/bit) for the real bit period.
module tb_key_frame_tx_scheduler;

    localparam int BC      = 4;
    localparam int GB      = 2;
    localparam int SEND_CY = 8 * BC;
    localparam int GAP_CY  = GB * BC;

    logic       clk = 1'b0;
    logic       rst, rst_s;
    logic [3:0] req, req_s;
    logic       tx_out, busy, done, tx_s, busy_s, done_s;
    logic [3:0] grant, grant_s;
    int         cycle = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    key_frame_tx_scheduler #(.BIT_CYCLES(BC), .GAP_BITS(GB)) dut (
        .CLK(clk), .RST(rst), .REQ(req),
        .TX_OUT(tx_out), .BUSY(busy), .GRANT(grant), .DONE(done)
    );

    key_frame_tx_scheduler #(.BIT_CYCLES(6250), .GAP_BITS(2)) dut_slow (
        .CLK(clk), .RST(rst_s), .REQ(req_s),
        .TX_OUT(tx_s), .BUSY(busy_s), .GRANT(grant_s), .DONE(done_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_req(input logic [3:0] r);
        req = r;
        @(negedge clk);
        req = 4'b0000;
    endtask

    task automatic watch_idle(input string tag, input int n);
        int cnt;
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            cnt += int'(busy);
        end
        check(tag, cnt, 0);
    endtask

    // Waits for LOAD, then checks grant, the full bit waveform, the gap, BUSY and DONE.
    // Returns at the negedge of the IDLE cycle after the gap.
    task automatic run_frame(input string tag, input logic [3:0] exp_grant,
                             input logic [7:0] exp_code, output int start_cyc);
        int          waited, busy_cnt, done_cnt;
        logic [31:0] wave, exp_wave;
        logic        gap_tx;
        waited    = 0;
        start_cyc = 0;
        while (busy !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (busy !== 1'b1) begin
            check({tag, "_start_timeout"}, 32'd0, 32'd1);
            return;
        end
        busy_cnt = 1;
        done_cnt = int'(done);
        @(negedge clk);
        start_cyc = cycle;
        check({tag, "_grant"}, grant, exp_grant);
        wave = '0;
        for (int i = 0; i < SEND_CY; i++) begin
            wave[SEND_CY-1-i] = tx_out;
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            @(negedge clk);
        end
        gap_tx = 1'b0;
        for (int i = 0; i < GAP_CY; i++) begin
            gap_tx |= tx_out;
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            if (i == GAP_CY - 1) check({tag, "_done_last_gap"}, done, 1'b1);
            @(negedge clk);
        end
        exp_wave = '0;
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < BC; c++)
                exp_wave[SEND_CY-1-(b*BC+c)] = exp_code[7-b];
        check({tag, "_wave"}, wave, exp_wave);
        check({tag, "_gap_low"}, gap_tx, 1'b0);
        check({tag, "_busy_len"}, busy_cnt, 41);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_idle_grant"}, grant, 4'b0000);
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, s2, s3, waited, n;
        rst = 1'b1; rst_s = 1'b1; req = 4'b0000; req_s = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant, 4'b0000);
        check("rst_done", done, 1'b0);
        rst = 1'b0; rst_s = 1'b0;
        @(negedge clk);

        // Single key0 pulse, then one request per key with the pointer walking forward.
        pulse_req(4'b0001);
        run_frame("key0", 4'b0001, 8'b1000_0000, s0);
        pulse_req(4'b1000);
        run_frame("key3", 4'b1000, 8'b1010_1010, s0);
        pulse_req(4'b0010);
        run_frame("key1", 4'b0010, 8'b1010_0000, s0);
        pulse_req(4'b0100);
        run_frame("key2", 4'b0100, 8'b1010_1000, s0);

        // Reset in the middle of a key3 frame, with all keys held high through reset.
        pulse_req(4'b1000);
        waited = 0;
        while (busy !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
        check("abort_started", busy, 1'b1);
        repeat (2 * BC + 1) @(negedge clk);
        check("abort_pre_tx", tx_out, 1'b1);
        rst = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        check("abort_tx", tx_out, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_grant", grant, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        watch_idle("held_no_frame", 20);
        req = 4'b0000;
        watch_idle("release_no_frame", 5);

        // All four keys in one cycle: served key0..key3, 42 cycles start to start.
        pulse_req(4'b1111);
        run_frame("all_k0", 4'b0001, 8'b1000_0000, s0);
        run_frame("all_k1", 4'b0010, 8'b1010_0000, s1);
        run_frame("all_k2", 4'b0100, 8'b1010_1000, s2);
        run_frame("all_k3", 4'b1000, 8'b1010_1010, s3);
        check("space_01", s1 - s0, 42);
        check("space_12", s2 - s1, 42);
        check("space_23", s3 - s2, 42);

        // Three key2 pulses during a key1 frame queue exactly one key2 frame.
        pulse_req(4'b0010);
        fork
            run_frame("dup_k1", 4'b0010, 8'b1010_0000, s0);
            begin
                repeat (4) @(negedge clk);
                pulse_req(4'b0100);
                repeat (5) @(negedge clk);
                pulse_req(4'b0100);
                repeat (8) @(negedge clk);
                pulse_req(4'b0100);
            end
        join
        run_frame("dup_k2", 4'b0100, 8'b1010_1000, s0);
        watch_idle("dup_single", 60);

        // A key1 edge landing on its own LOAD clear must queue a second key1 frame.
        pulse_req(4'b0001);
        fork
            run_frame("sw_k0", 4'b0001, 8'b1000_0000, s0);
            begin
                repeat (8) @(negedge clk);
                pulse_req(4'b0010);
            end
        join
        @(negedge clk);
        check("sw_load", busy, 1'b1);
        req = 4'b0010;
        fork
            run_frame("sw_k1a", 4'b0010, 8'b1010_0000, s0);
            begin
                @(negedge clk);
                req = 4'b0000;
            end
        join
        run_frame("sw_k1b", 4'b0010, 8'b1010_0000, s0);
        watch_idle("sw_after", 60);

        // Pointer now sits at key2; reset must bring it back to key0, so key1 beats key3.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_req(4'b1010);
        run_frame("ptr_k1", 4'b0010, 8'b1010_0000, s0);
        run_frame("ptr_k3", 4'b1000, 8'b1010_1010, s0);

        // Full-rate instance: key1 frame starts 1,0,1 with 6250-cycle (125 us) bits.
        req_s = 4'b0010;
        @(negedge clk);
        req_s = 4'b0000;
        waited = 0;
        while (busy_s !== 1'b1 && waited < 10) begin @(negedge clk); waited++; end
        check("slow_busy", busy_s, 1'b1);
        @(negedge clk);
        check("slow_grant", grant_s, 4'b0010);
        n = 0;
        while (tx_s === 1'b1 && n < 7000) begin @(negedge clk); n++; end
        check("slow_bit0_cycles", n, 6250);
        n = 0;
        while (tx_s === 1'b0 && n < 7000) begin @(negedge clk); n++; end
        check("slow_bit1_cycles", n, 6250);
        n = 0;
        while (tx_s === 1'b1 && n < 7000) begin @(negedge clk); n++; end
        check("slow_bit2_cycles", n, 6250);
        rst_s = 1'b1;
        @(negedge clk);
        check("slow_abort_busy", busy_s, 1'b0);
        rst_s = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_frame_tx_scheduler.md
# key_frame_tx_scheduler

Transmit-side controller for the CWRU transceiver link. It latches button requests from four keys and arbitrates between them round-robin. It serializes one 8-bit key frame at a time onto the single-wire link that the RX board samples on GPIO_1[17], and enforces the bit period and inter-frame gap the receiver decodes to its HEX0 display.

## Interface
- BIT_CYCLES, 6250: CLK cycles per serial bit (125 µs at 50 MHz).
- GAP_BITS, 2: idle bit periods (line low) after each frame.
- CLK  input  1  50 MHz system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  4  key requests, active-high; a rising edge queues that key.
- TX_OUT  output  1  serial line to the link, MSB first.
- BUSY  output  1  high from LOAD through the end of GAP.
- GRANT  output  4  one-hot key being sent; 0 when idle.
- DONE  output  1  one-cycle pulse on the last GAP cycle.

## Operation
- Frame codes, MSB first: key0 10000000, key1 10100000, key2 10101000, key3 10101010. Key k carries (k+1) "10" pairs, zero-filled.
- Edge detect: REQ_d holds last cycle's REQ. pending[k] is set on any edge where REQ[k] & ~REQ_d[k].
- Arbitration is round-robin. The pointer resets to 0 and searches pending from pointer upward with wrap-around. After granting key k, the pointer becomes (k+1) mod 4.
- IDLE: TX_OUT=0, BUSY=0, GRANT=0. If pending≠0, go to LOAD.
- LOAD (1 cycle):
  - latch the winner into GRANT and the shift register;
  - clear pending[winner];
  - update the pointer;
  - BUSY=1.
- SEND: TX_OUT = shift[7]. The bit counter runs 0..BIT_CYCLES-1 and shifts left on terminal count. After 8 bits, go to GAP.
- GAP: TX_OUT=0 for GAP_BITS·BIT_CYCLES cycles. DONE pulses on the final cycle, then IDLE, with GRANT cleared.
- Boundary rules:
  - **Set wins:** a new edge on the key being cleared in LOAD keeps its pending bit set.
  - **No duplicate queueing:** repeated edges while a key is already pending do not queue a second frame.
  - **Requests during a frame:** edges arriving in SEND or GAP are queued and never disturb the frame in flight.
  - **Simultaneous edges:** edges on several keys in the same cycle are all queued. They are served in round-robin order.
  - **Reset:**
    - REQ_d resets to 4'b1111, so keys held through reset do not fire.
    - pending, pointer, counters, GRANT and DONE reset to 0; TX_OUT resets to 0.
    - A reset mid-frame aborts the frame. The line is low on the next edge.

## Timing
- Edge on REQ sampled at edge N sets pending at N. IDLE→LOAD at N+1, LOAD→SEND at N+2.
- The first TX_OUT bit (always 1) appears after edge N+2 and lasts BIT_CYCLES cycles.
- Frame length is 8·BIT_CYCLES cycles; GAP is GAP_BITS·BIT_CYCLES cycles.
- Back-to-back frames: minimum spacing frame-start to frame-start is (8+GAP_BITS)·BIT_CYCLES+2 cycles (the extra 2 are the IDLE and LOAD cycles).
- Counter width is clog2(BIT_CYCLES). The bit index is 3 bits, and the gap counter is sized for GAP_BITS·BIT_CYCLES.
- All outputs are registered.

## Configuration
- REQ_SYNC_EN:
  - Defined: a two-flop synchronizer on each REQ bit precedes the edge detector. This adds 2 cycles of request latency, and the synchronizer flops reset to 1.
  - Undefined: REQ feeds the edge detector directly. REQ must then already be synchronous to CLK.

## Structure
- Shared package cwru_tx_pkg holds:
  - the state enum (IDLE, LOAD, SEND, GAP);
  - FRAME_BITS=8;
  - the four frame-code constants, which the RX decoder also uses.
- Sub-module rr_arbiter4 (pending[3:0], pointer[1:0] → one-hot grant plus valid) is combinational. It is instantiated once.

## Test plan
Use BIT_CYCLES=4 and GAP_BITS=2 for speed unless noted.
- Pulse REQ[0] for 1 cycle → GRANT=0001. TX_OUT shows 1 for 4 cycles then 0 for 28 cycles, plus 8 gap cycles low. DONE pulses once; BUSY is high for 41 cycles.
- Single request per key, with each frame sent before the next pulse: REQ[3] → 10101010, REQ[1] → 10100000, REQ[2] → 10101000. Each bit is exactly 4 cycles.
- REQ=1111 in one cycle → frames in order key0, key1, key2, key3. Each start is spaced 42 cycles apart.
- Pulse REQ[2] three times during a key1 frame → exactly one key2 frame follows.
- RST asserted at bit 3 of a key3 frame:
  - TX_OUT=0, BUSY=0, GRANT=0 on the next edge;
  - REQ held high through reset produces no frame;
  - the pointer restarts at key0.
- BIT_CYCLES=6250: a REQ[1] pulse yields a 10100000 frame with a 125000 ns bit period, matching the RX bench stimulus.
